// File: rtl/usb_tx_engine.sv
// USB full-speed transmit engine: SYNC, LSB-first payload with bit stuffing,
// NRZI line coding and EOP (SE0, SE0, J) onto the D+/D- pad drive outputs.
module usb_tx_engine #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       data_ack,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] fsm_state
);

    // Handshake: tx_data/tx_last are taken on the bit_tick edge at a byte boundary
    // when tx_valid is high; data_ack is high for the one cycle after that edge,
    // and upstream may present the next byte from then on.

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_AT = TW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [2:0]    ones_cnt;
    logic [7:0]    shift_reg;
    logic          last_reg;
    logic          bit_tick;
    logic [1:0]    line;

    assign bit_tick  = (state != IDLE) && (timer == TICK_AT);
    assign line      = {d_plus_out, d_minus_out};
    assign fsm_state = state;

    // A logical 0 swaps J and K; a logical 1 keeps the current line state.
    function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
        return b ? cur : ~cur;
    endfunction

    function automatic logic [2:0] ones_next(input logic [2:0] cnt, input logic b);
        return b ? cnt + 3'd1 : 3'd0;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            ones_cnt    <= '0;
            shift_reg   <= '0;
            last_reg    <= 1'b0;
            d_plus_out  <= 1'b1;
            d_minus_out <= 1'b0;
            tx_busy     <= 1'b0;
            data_ack    <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            data_ack <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            if (state == IDLE) begin
                timer <= '0;
            end else begin
                timer <= bit_tick ? '0 : timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (tx_start) begin
                        // First SYNC bit is a 0, so the line leaves J for K right away.
                        state                     <= SYNC;
                        tx_busy                   <= 1'b1;
                        bit_cnt                   <= '0;
                        ones_cnt                  <= '0;
                        {d_plus_out, d_minus_out} <= LINE_K;
                    end
                end

                SYNC: begin
                    if (bit_tick) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt                   <= bit_cnt + 3'd1;
                            {d_plus_out, d_minus_out} <= nrzi(line, bit_cnt == 3'd6);
                            ones_cnt                  <= ones_next(ones_cnt, bit_cnt == 3'd6);
                        end else if (tx_valid) begin
                            state                     <= DATA;
                            shift_reg                 <= tx_data;
                            last_reg                  <= tx_last;
                            data_ack                  <= 1'b1;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= nrzi(line, tx_data[0]);
                            ones_cnt                  <= ones_next(ones_cnt, tx_data[0]);
                        end else begin
                            tx_error                  <= 1'b1;
                            state                     <= EOP_SE0;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= LINE_SE0;
                        end
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        // shift_reg[0] is the bit just sent; a stuffed bit holds it, so the
                        // byte-boundary decision comes after any owed stuff bit.
                        if (ones_cnt == 3'd6) begin
                            {d_plus_out, d_minus_out} <= ~line;
                            ones_cnt                  <= '0;
                        end else if (bit_cnt != 3'd7) begin
                            bit_cnt                   <= bit_cnt + 3'd1;
                            shift_reg                 <= {1'b0, shift_reg[7:1]};
                            {d_plus_out, d_minus_out} <= nrzi(line, shift_reg[1]);
                            ones_cnt                  <= ones_next(ones_cnt, shift_reg[1]);
                        end else if (last_reg) begin
                            state                     <= EOP_SE0;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= LINE_SE0;
                        end else if (tx_valid) begin
                            shift_reg                 <= tx_data;
                            last_reg                  <= tx_last;
                            data_ack                  <= 1'b1;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= nrzi(line, tx_data[0]);
                            ones_cnt                  <= ones_next(ones_cnt, tx_data[0]);
                        end else begin
                            tx_error                  <= 1'b1;
                            state                     <= EOP_SE0;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= LINE_SE0;
                        end
                    end
                end

                EOP_SE0: begin
                    if (bit_tick) begin
                        if (bit_cnt == 3'd0) begin
                            bit_cnt <= 3'd1;
                        end else begin
                            state                     <= EOP_J;
                            bit_cnt                   <= '0;
                            {d_plus_out, d_minus_out} <= LINE_J;
                        end
                    end
                end

                EOP_J: begin
                    if (bit_tick) begin
                        state    <= IDLE;
                        tx_done  <= 1'b1;
                        tx_busy  <= 1'b0;
                        ones_cnt <= '0;
                    end
                end

                default: begin
                    state                     <= IDLE;
                    tx_busy                   <= 1'b0;
                    {d_plus_out, d_minus_out} <= LINE_J;
                end
            endcase
        end
    end

endmodule
